// File: rtl/puneh_mem_bridge_if.sv
// Controller-side and memory-side signals of the PUNEH memory bridge.
// The master modport is the bridge itself. The slave modport is the environment,
// meaning the controller strobes plus the external memory.
// The shared tri-state dataBus is a plain inout port on the bridge, so it is not part of this interface.
interface puneh_mem_bridge_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  // Controller / datapath side
  logic [AW-1:0] addrBus;
  logic          memRead;
  logic          memWrite;
  logic          busy;
  logic          done;
  logic          err;
  // Memory handshake side
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_req;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    input  addrBus, memRead, memWrite, mem_rdata, mem_ack,
    output busy, done, err, mem_addr, mem_wdata, mem_we, mem_req
  );

  modport slave (
    output addrBus, memRead, memWrite, mem_rdata, mem_ack,
    input  busy, done, err, mem_addr, mem_wdata, mem_we, mem_req
  );
endinterface

// File: rtl/puneh_mem_bridge.sv
// PUNEH memory bridge. It turns controller read/write strobes into a req/ack
// access to a variable-latency memory, with timeout detection.
// It reports busy/done/err back to the controller.
// During the FIN cycle of a read, the bridge drives the shared dataBus.
// Optional feature: define PUNEH_MEMBR_RDCACHE_EN to add a single-entry read cache.
module puneh_mem_bridge #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  puneh_mem_bridge_if.master bus,
  inout  wire  [DW-1:0]      dataBus
);

  typedef enum logic [1:0] {IDLE, REQ, FIN} bridgeState_t;

  // Timeout fires when the wait counter is at this value at an edge that has no ack.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  bridgeState_t  state;
  logic          busyReg;
  logic          doneReg;
  logic          errReg;
  logic          memReqReg;
  logic          memWeReg;
  logic [AW-1:0] memAddrReg;
  logic [DW-1:0] memWdataReg;
  logic [DW-1:0] rdataReg;
  logic [7:0]    waitCnt;
  logic          opRead;
  logic          timedOut;

  logic oneStrobe;
  logic bothStrobes;
  logic hitNow;

  assign oneStrobe   = bus.memRead ^ bus.memWrite;
  assign bothStrobes = bus.memRead & bus.memWrite;

`ifdef PUNEH_MEMBR_RDCACHE_EN
  logic [AW-1:0] cacheTag;
  logic [DW-1:0] cacheData;
  logic          cacheValid;

  // A read whose address matches a valid cache entry is served without a memory access.
  assign hitNow = bus.memRead && !bus.memWrite && cacheValid && (bus.addrBus == cacheTag);
`else
  assign hitNow = 1'b0;
`endif

  // Access sequencer: IDLE -> REQ -> FIN -> IDLE. All outputs are registered.
  // NOTE: every register here uses non-blocking (<=), so each branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
      errReg      <= 1'b0;
      memReqReg   <= 1'b0;
      memWeReg    <= 1'b0;
      memAddrReg  <= '0;
      memWdataReg <= '0;
      rdataReg    <= '0;
      waitCnt     <= '0;
      opRead      <= 1'b0;
      timedOut    <= 1'b0;
`ifdef PUNEH_MEMBR_RDCACHE_EN
      cacheTag    <= '0;
      cacheData   <= '0;
      cacheValid  <= 1'b0;
`endif
    end else begin
      // NOTE: done and err are single-cycle pulses. They default low here, and the branches below only raise them.
      doneReg <= 1'b0;
      errReg  <= 1'b0;
      case (state)
        IDLE: begin
          if (bothStrobes) begin
            errReg <= 1'b1;
          end else if (oneStrobe) begin
            memAddrReg <= bus.addrBus;
            if (bus.memWrite) begin
              memWdataReg <= dataBus;
            end
            opRead   <= bus.memRead;
            timedOut <= 1'b0;
            waitCnt  <= '0;
            busyReg  <= 1'b1;
            if (hitNow) begin
`ifdef PUNEH_MEMBR_RDCACHE_EN
              rdataReg <= cacheData;
`endif
              doneReg <= 1'b1;
              state   <= FIN;
            end else begin
              memWeReg  <= bus.memWrite;
              memReqReg <= 1'b1;
              state     <= REQ;
            end
          end
        end

        REQ: begin
          if (bus.mem_ack) begin
            if (opRead) begin
              rdataReg <= bus.mem_rdata;
            end
`ifdef PUNEH_MEMBR_RDCACHE_EN
            if (opRead) begin
              cacheTag   <= memAddrReg;
              cacheData  <= bus.mem_rdata;
              cacheValid <= 1'b1;
            end else if (memAddrReg == cacheTag) begin
              cacheData <= memWdataReg;
            end
`endif
            memReqReg <= 1'b0;
            memWeReg  <= 1'b0;
            doneReg   <= 1'b1;
            state     <= FIN;
          end else if (waitCnt == LAST_WAIT) begin
`ifdef PUNEH_MEMBR_RDCACHE_EN
            if (memAddrReg == cacheTag) begin
              cacheValid <= 1'b0;
            end
`endif
            memReqReg <= 1'b0;
            memWeReg  <= 1'b0;
            timedOut  <= 1'b1;
            doneReg   <= 1'b1;
            errReg    <= 1'b1;
            state     <= FIN;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end

        FIN: begin
          busyReg <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The bridge drives the shared bus only in the FIN cycle of a read.
  // A timed-out read returns all ones.
  assign dataBus = (state == FIN && opRead) ? (timedOut ? {DW{1'b1}} : rdataReg)
                                            : {DW{1'bz}};

  assign bus.busy      = busyReg;
  assign bus.done      = doneReg;
  assign bus.err       = errReg;
  assign bus.mem_req   = memReqReg;
  assign bus.mem_we    = memWeReg;
  assign bus.mem_addr  = memAddrReg;
  assign bus.mem_wdata = memWdataReg;

endmodule

// File: tb/tb_puneh_mem_bridge.sv
// Self-checking bench for puneh_mem_bridge.
// The stimulus pushes the expected done/err events into a queue, and a monitor
// pops each event and checks it when the DUT presents it.
// The bench releases the shared bus only where the bridge is expected to drive it.
// Everywhere else the bench holds the bus at a known value, so a stray bridge drive shows up.
module tb_puneh_mem_bridge;
  localparam int DW      = 16;
  localparam int AW      = 16;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wire  [DW-1:0] dataBus;
  logic          tbDrive = 1'b1;
  logic [DW-1:0] tbVal   = '0;
  assign dataBus = tbDrive ? tbVal : {DW{1'bz}};

  puneh_mem_bridge_if #(.DW(DW), .AW(AW)) bif ();

  puneh_mem_bridge #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bif),
    .dataBus(dataBus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            atCyc;
    bit            isDone;
    bit            isErr;
    bit            chkBus;
    logic [DW-1:0] data;
  } exp_t;

  exp_t expQ[$];

  // Cache reference model: it holds the last successful read,
  // is overwritten by acked writes to the same address,
  // and is invalidated by a timeout on that address.
  logic [AW-1:0] cTag   = '0;
  logic [DW-1:0] cData  = '0;
  bit            cValid = 1'b0;

  // Monitor: on every cycle it checks bus ownership, and it matches each done/err pulse against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) continue;
      if (tbDrive) check("busHold", dataBus, tbVal);
      if (bif.done || bif.err) begin
        if (expQ.size() == 0) begin
          check("unexpectedPulse", {30'd0, bif.done, bif.err}, 32'd0);
        end else begin
          e = expQ.pop_front();
          check("pulseCycle", cyc, e.atCyc);
          check("done", bif.done, e.isDone);
          check("err", bif.err, e.isErr);
          if (e.chkBus) check("readData", dataBus, e.data);
        end
      end
    end
  end

  // kind: 0 = read, 1 = write, 2 = both strobes. waits < 0 means the memory never acks.
  task automatic access(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int waits, input logic [DW-1:0] rdata);
    int            s;
    int            doneCyc;
    bit            hit;
    logic [DW-1:0] expData;
    @(negedge clk);
    s = cyc + 1;
    bif.addrBus = addr;
    bif.mem_ack = 1'b0;
    if (kind == 2) begin
      bif.memRead  = 1'b1;
      bif.memWrite = 1'b1;
      tbDrive      = 1'b1;
      tbVal        = '0;
      expQ.push_back('{s, 1'b0, 1'b1, 1'b0, '0});
      @(posedge clk);
      #1;
      check("conflictBusy", bif.busy, 1'b0);
      check("conflictReq", bif.mem_req, 1'b0);
      @(negedge clk);
      bif.memRead  = 1'b0;
      bif.memWrite = 1'b0;
      return;
    end
    hit = 1'b0;
`ifdef PUNEH_MEMBR_RDCACHE_EN
    hit = (kind == 0) && cValid && (cTag == addr);
`endif
    if (hit)            doneCyc = s;
    else if (waits < 0) doneCyc = s + TIMEOUT;
    else                doneCyc = s + 1 + waits;
    if (hit)            expData = cData;
    else if (waits < 0) expData = '1;
    else                expData = rdata;
    expQ.push_back('{doneCyc, 1'b1, (waits < 0) && !hit, kind == 0, expData});
    bif.memRead  = (kind == 0);
    bif.memWrite = (kind == 1);
    tbVal        = (kind == 1) ? wdata : '0;
    tbDrive      = !hit;
    for (int c = s; c <= doneCyc; c++) begin
      @(posedge clk);
      #1;
      check("busyHigh", bif.busy, 1'b1);
      if (c < doneCyc) begin
        check("reqHigh", bif.mem_req, 1'b1);
        check("memAddr", bif.mem_addr, addr);
        check("memWe", bif.mem_we, kind == 1);
        if (kind == 1) check("memWdata", bif.mem_wdata, wdata);
      end else begin
        check("reqLowFin", bif.mem_req, 1'b0);
      end
      @(negedge clk);
      tbVal = '0;
      if (c < doneCyc) begin
        bif.memRead  = ($urandom_range(0, 3) == 0);
        bif.memWrite = ($urandom_range(0, 3) == 0);
        bif.addrBus  = AW'($urandom);
        tbDrive      = !((kind == 0) && (c == doneCyc - 1));
        bif.mem_ack  = !hit && (waits >= 0) && (c == s + waits);
        bif.mem_rdata = bif.mem_ack ? rdata : DW'($urandom);
      end else begin
        bif.memRead   = 1'b0;
        bif.memWrite  = 1'b0;
        tbDrive       = 1'b1;
        bif.mem_ack   = ($urandom_range(0, 1) == 1);
        bif.mem_rdata = DW'($urandom);
      end
    end
    @(posedge clk);
    #1;
    check("busyLowAfter", bif.busy, 1'b0);
    check("reqLowAfter", bif.mem_req, 1'b0);
    if (kind == 0) begin
      if (!hit && waits >= 0) begin
        cTag = addr; cData = rdata; cValid = 1'b1;
      end else if (!hit && addr == cTag) begin
        cValid = 1'b0;
      end
    end else if (waits >= 0) begin
      if (addr == cTag) cData = wdata;
    end else if (addr == cTag) begin
      cValid = 1'b0;
    end
  endtask

  // Idle cycles with stray acks, which the bridge must ignore.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bif.mem_ack   = ($urandom_range(0, 1) == 1);
      bif.mem_rdata = DW'($urandom);
      @(posedge clk);
      #1;
      check("idleReqLow", bif.mem_req, 1'b0);
    end
    @(negedge clk);
    bif.mem_ack = 1'b0;
  endtask

  // Reset pulsed during the second REQ cycle of a read. No done may follow it.
  task automatic resetMidAccess(input logic [AW-1:0] addr);
    @(negedge clk);
    bif.addrBus = addr;
    bif.memRead = 1'b1;
    bif.mem_ack = 1'b0;
    @(posedge clk);
    #1;
    check("rstReq1", bif.mem_req, 1'b1);
    @(negedge clk);
    bif.memRead = 1'b0;
    @(posedge clk);
    #1;
    check("rstReq2", bif.mem_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rstReqDrop", bif.mem_req, 1'b0);
    check("rstBusy", bif.busy, 1'b0);
    check("rstDone", bif.done, 1'b0);
    cValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] pool [4];
    int            r;
    int            kind;
    int            waits;
    bif.addrBus   = '0;
    bif.memRead   = 1'b0;
    bif.memWrite  = 1'b0;
    bif.mem_rdata = '0;
    bif.mem_ack   = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rstBusy0", bif.busy, 1'b0);
    check("rstDone0", bif.done, 1'b0);
    check("rstErr0", bif.err, 1'b0);
    check("rstMemReq0", bif.mem_req, 1'b0);
    check("rstMemWe0", bif.mem_we, 1'b0);
    check("rstMemAddr0", bif.mem_addr, 32'd0);
    check("rstMemWdata0", bif.mem_wdata, 32'd0);
    check("rstBusRel", dataBus, tbVal);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    access(0, 16'h0040, '0, 0, 16'hBEEF);
    access(1, 16'h0100, 16'h1234, 3, '0);
    access(0, 16'h0200, '0, -1, '0);
    access(2, 16'h0300, '0, 0, '0);
    idleCycles(3);
    resetMidAccess(16'h0300);
    access(0, 16'h0040, '0, 0, 16'hBEEF);
    access(0, 16'h0040, '0, 2, 16'hAAAA);
    access(1, 16'h0040, 16'h5555, 1, '0);
    access(0, 16'h0040, '0, 0, 16'h7777);
    access(1, 16'h0040, 16'h6666, -1, '0);
    access(0, 16'h0040, '0, 1, 16'h1111);

    pool[0] = 16'h0040;
    pool[1] = 16'h0041;
    pool[2] = 16'h0100;
    for (int t = 0; t < 60; t++) begin
      pool[3] = AW'($urandom);
      r = $urandom_range(0, 19);
      kind  = (r < 9) ? 0 : ((r < 18) ? 1 : 2);
      waits = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, TIMEOUT - 1);
      access(kind, pool[$urandom_range(0, 3)], DW'($urandom), waits, DW'($urandom_range(1, 65535)));
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 2));
    end

    idleCycles(4);
    check("queueEmpty", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/puneh_mem_bridge.md
Name: puneh_mem_bridge

Overview:
- Memory-side stage directly downstream of the PUNEH datapath.
- Consumes the datapath's addrBus and shared tri-state dataBus, plus memRead/memWrite strobes from the controller.
- Runs a req/ack handshake with a variable-latency external memory, with timeout detection.
- Reports busy/done/err so the controller can stall its state machine until the access completes.

Parameters:
- DW, 16, data width; must match datapath dataBus.
- AW, 16, address width; must match datapath addrBus.
- TIMEOUT, 15, maximum cycles spent in REQ without mem_ack; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- addrBus  input  AW  address from datapath.
- dataBus  inout  DW  shared datapath bus; driven by bridge only in FIN of a read, else high-Z.
- memRead  input  1  controller read strobe; sampled in IDLE only.
- memWrite  input  1  controller write strobe; sampled in IDLE only.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse in FIN.
- err  output  1  one-cycle pulse (timeout or illegal request).
- mem_addr  output  AW  registered address to memory.
- mem_wdata  output  DW  registered write data.
- mem_we  output  1  1 = write, valid while mem_req.
- mem_req  output  1  request; held high until ack or timeout.
- mem_rdata  input  DW  read data; valid when mem_ack = 1.
- mem_ack  input  1  memory acknowledge, one cycle.

Behaviour:
- Reset (async, rst = 1):
  - state = IDLE.
  - busy, done, err, mem_req, mem_we = 0.
  - mem_addr, mem_wdata, rdata_reg = 0.
  - dataBus released to Z; cycle counter = 0.
  - Asserting rst mid-access drops mem_req immediately, discards the transaction and produces no done.
- States: IDLE, REQ, FIN.
- IDLE:
  - Exactly one strobe high at an edge: latch addrBus into mem_addr, latch dataBus into mem_wdata (writes only), set op flag, mem_we = memWrite, clear counter, go REQ.
  - memRead and memWrite both high: no access; err pulses the next cycle; stay IDLE.
- REQ:
  - mem_req = 1.
  - Edge with mem_ack = 1: latch mem_rdata into rdata_reg (reads), go FIN.
  - Edge without ack: counter += 1. If counter == TIMEOUT-1 at that edge, go FIN with timeout flag set.
  - Strobes arriving while busy are ignored, not queued.
- FIN (exactly one cycle, then IDLE):
  - done = 1; mem_req = 0.
  - Read: dataBus driven with rdata_reg, or 16'hFFFF on timeout.
  - Timeout: err = 1 in the same cycle as done.
- Latency: zero-wait ack (mem_ack high in the first REQ cycle) gives done in the 2nd cycle after the strobe edge. Each memory wait cycle adds 1.
- mem_ack outside REQ is ignored.
- Counter is 8 bits; no wrap, since the timeout fires first.

Optional Feature:
- Macro: PUNEH_MEMBR_RDCACHE_EN.
- Enabled:
  - Single-entry read cache (tag, data, valid).
  - A read in IDLE whose addrBus equals tag with valid = 1 goes straight to FIN, skips REQ and drives cached data. done arrives 1 cycle after the strobe edge; mem_req is never raised.
  - A successful read fills the entry.
  - A write to the tag address updates cached data when acked.
  - A timed-out access to the tag address clears valid.
  - Reset clears valid.
- Disabled: no cache state; every read goes through REQ.

Test Plan:
- Zero-wait read: addrBus = 16'h0040, memRead pulse, mem_ack in first REQ cycle with mem_rdata = 16'hBEEF -> mem_req high 1 cycle, done 2 cycles after strobe, dataBus = 16'hBEEF during done, Z otherwise.
- Write with 3 wait cycles: addrBus = 16'h0100, dataBus = 16'h1234, memWrite, ack on 4th REQ cycle -> mem_we = 1, mem_wdata = 16'h1234 stable for 4 cycles, done 5 cycles after strobe, dataBus never driven.
- Timeout: read, mem_ack never asserted, TIMEOUT = 15 -> mem_req high exactly 15 cycles, then done and err together, dataBus = 16'hFFFF.
- Conflicts and stalls: memRead and memWrite high together -> err pulse, no mem_req. New strobe while busy -> ignored, single transaction. Stray mem_ack in IDLE -> no effect.
- Reset mid-access: rst pulsed in 2nd REQ cycle -> mem_req low asynchronously, no done, next read completes normally.
- With PUNEH_MEMBR_RDCACHE_EN: read 16'h0040 (miss, 16'hBEEF), repeat -> done 1 cycle after strobe, no mem_req. Write 16'h0040 = 16'h5555, then read -> 16'h5555 from cache.
